// File: rtl/beat_interval_averager.sv
// Averages N_SAMPLES 8-bit beat intervals using an external 8-bit combinational
// adder, two byte-additions per sample, and emits the truncated window mean.
module beat_interval_averager #(
  parameter int N_SAMPLES = 4,
  parameter int SHIFT     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        sample_valid,
  input  logic [7:0]  sample,
  output logic        sample_ready,
  output logic [7:0]  add_a,
  output logic [7:0]  add_b,
  output logic        add_ci,
  input  logic [7:0]  add_y,
  input  logic        add_c,
  output logic [15:0] sum,
  output logic [7:0]  avg,
  output logic        avg_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD_LO = 2'd1,
    ADD_HI = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [4:0] LAST_CNT = 5'(N_SAMPLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  samp_q, samp_d;
  logic [15:0] sum_q, sum_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        cy_q, cy_d;
  logic [7:0]  avg_q, avg_d;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      samp_q  <= 8'd0;
      sum_q   <= 16'd0;
      cnt_q   <= 5'd0;
      cy_q    <= 1'b0;
      avg_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      avg_q   <= avg_d;
    end
  end

  // Next-state, datapath updates and adder operand selection
  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    avg_d   = avg_q;
    add_a   = 8'd0;
    add_b   = 8'd0;
    add_ci  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          samp_d  = sample;
          state_d = ADD_LO;
        end else begin
          state_d = IDLE;
        end
      end
      ADD_LO: begin
        add_a       = sum_q[7:0];
        add_b       = samp_q;
        sum_d[7:0]  = add_y;
        cy_d        = add_c;
        state_d     = ADD_HI;
      end
      ADD_HI: begin
        add_a  = sum_q[15:8];
        add_ci = cy_q;
        // The final window sum exists only on the adder output this cycle
        if (cnt_q == LAST_CNT) begin
          avg_d   = 8'({add_y, sum_q[7:0]} >> SHIFT);
          sum_d   = 16'd0;
          cnt_d   = 5'd0;
          state_d = DONE;
        end else begin
          sum_d[15:8] = add_y;
          cnt_d       = cnt_q + 5'd1;
          state_d     = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (clear) begin
      samp_d  = samp_q;
      sum_d   = 16'd0;
      cnt_d   = 5'd0;
      cy_d    = 1'b0;
      avg_d   = avg_q;
      state_d = IDLE;
    end else begin
      state_d = state_d;
    end
  end

  assign sample_ready = (state_q == IDLE);
  assign avg_valid    = (state_q == DONE);
  assign sum          = sum_q;
  assign avg          = avg_q;

endmodule

// File: tb/tb_beat_interval_averager.sv
// Scoreboard bench for beat_interval_averager: N=4 and N=16 instances, each
// with a behavioural combinational adder on its add_* ports.
module tb_beat_interval_averager;

  logic clk = 1'b0;
  logic reset, clear;
  logic sv4, sv16;
  logic [7:0] s4, s16;
  logic rdy4, rdy16, aci4, aci16, ac4, ac16, av4, av16;
  logic [7:0] aa4, ab4, ay4, aa16, ab16, ay16, avg4, avg16;
  logic [15:0] sum4, sum16;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] q4[$];
  logic [7:0] q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign {ac4, ay4}   = 9'(aa4) + 9'(ab4) + 9'(aci4);
  assign {ac16, ay16} = 9'(aa16) + 9'(ab16) + 9'(aci16);

  beat_interval_averager #(.N_SAMPLES(4), .SHIFT(2)) dut4 (
    .clk(clk), .reset(reset), .clear(clear), .sample_valid(sv4), .sample(s4),
    .sample_ready(rdy4), .add_a(aa4), .add_b(ab4), .add_ci(aci4),
    .add_y(ay4), .add_c(ac4), .sum(sum4), .avg(avg4), .avg_valid(av4));

  beat_interval_averager #(.N_SAMPLES(16), .SHIFT(4)) dut16 (
    .clk(clk), .reset(reset), .clear(clear), .sample_valid(sv16), .sample(s16),
    .sample_ready(rdy16), .add_a(aa16), .add_b(ab16), .add_ci(aci16),
    .add_y(ay16), .add_c(ac16), .sum(sum16), .avg(avg16), .avg_valid(av16));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Monitor: every avg_valid pulse consumes one expected mean
  always @(negedge clk) begin
    if (av4 === 1'b1) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL avg4_unexpected actual=%0d required=no_pulse", avg4);
      end else begin
        chk("avg4", int'(avg4), int'(q4.pop_front()));
      end
    end
    if (av16 === 1'b1) begin
      if (q16.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL avg16_unexpected actual=%0d required=no_pulse", avg16);
      end else begin
        chk("avg16", int'(avg16), int'(q16.pop_front()));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input bit big, input logic [7:0] v, output int acc);
    int n;
    n = 0;
    while (!(big ? rdy16 : rdy4) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=busy required=ready");
    end
    if (big) begin
      sv16 = 1'b1;
      s16  = v;
    end else begin
      sv4 = 1'b1;
      s4  = v;
    end
    @(negedge clk);
    acc  = cyc;
    sv4  = 1'b0;
    sv16 = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3, tx;
    reset = 1'b1; clear = 1'b0;
    sv4 = 1'b0; sv16 = 1'b0; s4 = 8'd0; s16 = 8'd0;
    wait_neg(3);
    chk("rst_ready", rdy4, 1);
    chk("rst_sum", sum4, 0);
    chk("rst_avg", avg4, 0);
    chk("rst_avg_valid", av4, 0);
    chk("rst_add_a", aa4, 0);
    chk("rst_add_b", ab4, 0);
    chk("rst_add_ci", aci4, 0);
    reset = 1'b0;
    wait_neg(1);

    // Basic window: 100,120,110,130 -> 115
    send(1'b0, 8'd100, t0);
    send(1'b0, 8'd120, t1);
    chk("interval_1", t1 - t0, 3);
    send(1'b0, 8'd110, t2);
    chk("interval_2", t2 - t1, 3);
    wait_neg(2);
    chk("sum_after_3", sum4, 330);
    q4.push_back(8'd115);
    send(1'b0, 8'd130, t3);
    chk("interval_3", t3 - t2, 3);
    wait_neg(2);
    chk("done_valid", av4, 1);
    chk("done_sum", sum4, 0);
    chk("done_ready", rdy4, 0);
    wait_neg(1);

    // Carry path: 200 x4
    send(1'b0, 8'd200, tx);
    send(1'b0, 8'd200, tx);
    chk("carry_lo_a", aa4, 200);
    chk("carry_lo_b", ab4, 200);
    wait_neg(1);
    chk("carry_hi_ci", aci4, 1);
    wait_neg(1);
    chk("carry_sum", sum4, 16'h0190);
    q4.push_back(8'd200);
    send(1'b0, 8'd200, tx);
    send(1'b0, 8'd200, tx);
    wait_neg(3);

    // Truncation: 1,1,1,2 -> 5/4 = 1
    q4.push_back(8'd1);
    send(1'b0, 8'd1, tx);
    send(1'b0, 8'd1, tx);
    send(1'b0, 8'd1, tx);
    send(1'b0, 8'd2, tx);
    wait_neg(3);

    // Clear in ADD_LO of the 3rd sample
    send(1'b0, 8'd10, tx);
    send(1'b0, 8'd20, tx);
    send(1'b0, 8'd30, tx);
    clear = 1'b1;
    wait_neg(1);
    clear = 1'b0;
    chk("clear_sum", sum4, 0);
    chk("clear_ready", rdy4, 1);
    chk("clear_avg_held", avg4, 1);
    chk("clear_avg_valid", av4, 0);
    clear = 1'b1; sv4 = 1'b1; s4 = 8'd77;
    wait_neg(1);
    clear = 1'b0; sv4 = 1'b0;
    chk("clear_blocks_accept", rdy4, 1);
    chk("clear_blocks_sum", sum4, 0);
    q4.push_back(8'd25);
    send(1'b0, 8'd10, tx);
    send(1'b0, 8'd20, tx);
    send(1'b0, 8'd30, tx);
    wait_neg(2);
    chk("avg_held_pre_final", avg4, 1);
    send(1'b0, 8'd40, tx);
    wait_neg(3);

    // Reset in ADD_HI
    send(1'b0, 8'd50, tx);
    wait_neg(1);
    reset = 1'b1;
    wait_neg(1);
    reset = 1'b0;
    chk("hi_rst_sum", sum4, 0);
    chk("hi_rst_avg", avg4, 0);
    chk("hi_rst_avg_valid", av4, 0);
    chk("hi_rst_ready", rdy4, 1);
    chk("hi_rst_add_a", aa4, 0);
    chk("hi_rst_add_b", ab4, 0);
    chk("hi_rst_add_ci", aci4, 0);

    // Valid held through DONE: accepted only in the following IDLE
    q4.push_back(8'd10);
    send(1'b0, 8'd10, tx);
    send(1'b0, 8'd10, tx);
    send(1'b0, 8'd10, tx);
    send(1'b0, 8'd10, tx);
    sv4 = 1'b1; s4 = 8'd90;
    wait_neg(2);
    chk("hold_done_ready", rdy4, 0);
    wait_neg(1);
    chk("hold_idle_ready", rdy4, 1);
    wait_neg(1);
    sv4 = 1'b0;
    chk("hold_lo_b", ab4, 90);
    wait_neg(2);
    chk("hold_sum", sum4, 90);

    // Upper bound, N=16: 255 x16 -> 255
    q16.push_back(8'd255);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        wait_neg(2);
        chk("n16_sum_pre_final", sum16, 3825);
      end
      send(1'b1, 8'd255, tx);
      if (i == 15) begin
        wait_neg(1);
        chk("n16_hi_full", int'({ay16, sum16[7:0]}), 16'h0FF0);
        chk("n16_hi_ci", aci16, 1);
      end
    end
    wait_neg(3);
    chk("n16_sum_after", sum16, 0);

    chk("q4_drained", q4.size(), 0);
    chk("q16_drained", q16.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
